// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared mode encoding for the LED PWM fader
package led_pwm_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

endpackage

// File: rtl/led_pwm_fader_if.sv
// rtl/led_pwm_fader_if.sv - valid/ready config write port of the LED PWM fader
interface led_pwm_fader_if
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CHAN_W-1:0]   cfg_chan;
    logic [MODE_W-1:0]   cfg_mode;
    logic [PWM_BITS-1:0] cfg_level;

    modport master (
        output cfg_valid, cfg_chan, cfg_mode, cfg_level,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_mode, cfg_level,
        output cfg_ready
    );

endinterface

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one PWM channel: shadow/active config, blink/breathe state, duty compare (gamma via LED_PWM_GAMMA_EN)
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int BLINK_SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  mode_t               wr_mode,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic                boundary,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pwm_out
);

    mode_t                  sh_mode, act_mode, nx_mode;
    logic [PWM_BITS-1:0]    sh_level, nx_level;
    logic [BLINK_SHIFT-1:0] blink_cnt, blink_nx;
    logic                   phase, phase_nx;
    logic [PWM_BITS-1:0]    ramp, ramp_nx;
    logic                   ramp_down, down_nx;
    logic [PWM_BITS-1:0]    duty, duty_nx, lin;
    logic                   restart;

`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0]  sq;
    assign sq = (2*PWM_BITS)'(lin) * (2*PWM_BITS)'(lin);
`endif

    // A write landing in the boundary cycle must be seen by that boundary.
    assign nx_mode  = wr_en ? wr_mode  : sh_mode;
    assign nx_level = wr_en ? wr_level : sh_level;
    assign restart  = (nx_mode != act_mode) &&
                      ((nx_mode == MODE_BLINK) || (nx_mode == MODE_BREATHE));

    always_comb begin
        blink_nx = blink_cnt;
        phase_nx = phase;
        ramp_nx  = ramp;
        down_nx  = ramp_down;
        lin      = '0;
        if (restart) begin
            blink_nx = '0;
            phase_nx = 1'b1;
            ramp_nx  = '0;
            down_nx  = 1'b0;
        end else if (nx_mode == MODE_BLINK) begin
            blink_nx = blink_cnt + BLINK_SHIFT'(1);
            if (&blink_cnt) phase_nx = ~phase;
        end else if (nx_mode == MODE_BREATHE) begin
            // Ramp at or above level always heads down, which also covers a level cut.
            if (nx_level == '0) begin
                ramp_nx = '0;
                down_nx = 1'b0;
            end else if (ramp >= nx_level) begin
                ramp_nx = ramp - PWM_BITS'(1);
                down_nx = 1'b1;
            end else if (ramp_down && (ramp == '0)) begin
                ramp_nx = ramp + PWM_BITS'(1);
                down_nx = 1'b0;
            end else if (ramp_down) begin
                ramp_nx = ramp - PWM_BITS'(1);
            end else begin
                ramp_nx = ramp + PWM_BITS'(1);
            end
        end
        case (nx_mode)
            MODE_OFF:     lin = '0;
            MODE_SOLID:   lin = nx_level;
            MODE_BLINK:   lin = phase_nx ? nx_level : '0;
            MODE_BREATHE: lin = ramp_nx;
            default:      lin = '0;
        endcase
`ifdef LED_PWM_GAMMA_EN
        duty_nx = (&lin) ? lin : sq[2*PWM_BITS-1:PWM_BITS];
`else
        duty_nx = lin;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode   <= MODE_OFF;
            sh_level  <= '0;
            act_mode  <= MODE_OFF;
            blink_cnt <= '0;
            phase     <= 1'b1;
            ramp      <= '0;
            ramp_down <= 1'b0;
            duty      <= '0;
            pwm_out   <= 1'b0;
        end else begin
            if (wr_en) begin
                sh_mode  <= wr_mode;
                sh_level <= wr_level;
            end
            if (boundary) begin
                act_mode  <= nx_mode;
                blink_cnt <= blink_nx;
                phase     <= phase_nx;
                ramp      <= ramp_nx;
                ramp_down <= down_nx;
                duty      <= duty_nx;
            end
            pwm_out <= (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - multi-channel LED PWM fader top: prescaler, PWM counter, config decode (LED_PWM_GAMMA_EN selects gamma)
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int PWM_BITS     = 8,
    parameter int PRESCALE_DIV = 188,
    parameter int BLINK_SHIFT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    led_pwm_fader_if.slave      cfg,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PS_W   = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0]     ps_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                boundary;
    logic                ready_q;
    logic                wr_fire;

    assign tick        = (ps_cnt == PS_LAST);
    assign boundary    = tick && (&pwm_cnt);
    assign period_tick = boundary;
    assign cfg.cfg_ready = ready_q;
    assign wr_fire     = cfg.cfg_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt  <= '0;
            pwm_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            ps_cnt  <= tick ? '0 : ps_cnt + PS_W'(1);
            if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Out-of-range channel numbers match no instance, so such writes vanish.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_pwm_channel #(
            .PWM_BITS    (PWM_BITS),
            .BLINK_SHIFT (BLINK_SHIFT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_fire && (cfg.cfg_chan == CHAN_W'(i))),
            .wr_mode  (mode_t'(cfg.cfg_mode)),
            .wr_level (cfg.cfg_level),
            .boundary (boundary),
            .pwm_cnt  (pwm_cnt),
            .pwm_out  (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed bench for led_pwm_fader (gamma cases under LED_PWM_GAMMA_EN)
module tb_led_pwm_fader;

    localparam int M_OFF = 0, M_SOLID = 1, M_BLINK = 2, M_BREATHE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] pwm_out;
    logic       period_tick;
    int         n_checks = 0;
    int         n_fail = 0;

    led_pwm_fader_if #(.CHANNELS(3), .PWM_BITS(8)) cfg_if ();

    led_pwm_fader #(
        .CHANNELS     (3),
        .PWM_BITS     (8),
        .PRESCALE_DIV (1),
        .BLINK_SHIFT  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    function automatic int exp_duty(input int d);
`ifdef LED_PWM_GAMMA_EN
        return (d == 255) ? 255 : (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    task automatic drive_cfg(input int ch, input int mode, input int lvl);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = 2'(ch);
        cfg_if.cfg_mode  = 2'(mode);
        cfg_if.cfg_level = 8'(lvl);
    endtask

    task automatic step_write(input int ch, input int mode, input int lvl);
        drive_cfg(ch, mode, lvl);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic step_idle();
        @(negedge clk);
    endtask

    task automatic wait_boundary(input int limit);
        int  k = 0;
        bit  seen = 0;
        while (k < limit && !seen) begin
            @(negedge clk);
            if (period_tick) seen = 1;
            k++;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_boundary: no period_tick within %0d cycles", limit);
        end
    endtask

    // Counts high cycles of one full period; optional writes land mid-period.
    task automatic measure(input int n_wr, input int wch, input int wmode,
                           input int la, input int lb,
                           output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) @(negedge clk);
            c0 += int'(pwm_out[0]);
            c1 += int'(pwm_out[1]);
            c2 += int'(pwm_out[2]);
            if (n_wr >= 1 && k == 100)      drive_cfg(wch, wmode, la);
            else if (n_wr == 2 && k == 101) drive_cfg(wch, wmode, lb);
            else                            cfg_if.cfg_valid = 1'b0;
        end
        n_checks++;
        if (period_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL period_align: period_tick=%0b required 1", period_tick);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: high ticks %0d required %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan  = '0;
        cfg_if.cfg_mode  = '0;
        cfg_if.cfg_level = '0;
        repeat (5) @(negedge clk);
        n_checks += 3;
        if (pwm_out !== 3'b000) begin n_fail++; $display("FAIL reset_pwm: %b required 000", pwm_out); end
        if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: %b required 0", period_tick); end
        if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: %b required 0", cfg_if.cfg_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: %b required 1", cfg_if.cfg_ready); end
        if (pwm_out !== 3'b000) begin n_fail++; $display("FAIL pwm_after_reset: %b required 000", pwm_out); end
        wait_boundary(600);
    endtask

    task automatic test_solid();
        int c0, c1, c2;
        step_write(0, M_SOLID, 64);
        measure(0, 0, 0, 0, 0, c0, c1, c2);
        check_cnt("solid_ch0", c0, exp_duty(64));
        check_cnt("solid_ch1", c1, 0);
        check_cnt("solid_ch2", c2, 0);
    endtask

    task automatic test_boundary_sync();
        int c0, c1, c2;
        step_idle();
        measure(2, 1, M_SOLID, 200, 10, c0, c1, c2);
        check_cnt("sync_ch1_same_period", c1, 0);
        check_cnt("sync_ch0_kept", c0, exp_duty(64));
        step_idle();
        measure(0, 0, 0, 0, 0, c0, c1, c2);
        check_cnt("sync_ch1_last_wins", c1, exp_duty(10));
    endtask

    task automatic test_ignored_chan();
        int c0, c1, c2;
        step_write(3, M_SOLID, 255);
        measure(0, 0, 0, 0, 0, c0, c1, c2);
        check_cnt("bad_chan_ch0", c0, exp_duty(64));
        check_cnt("bad_chan_ch1", c1, exp_duty(10));
        check_cnt("bad_chan_ch2", c2, 0);
    endtask

    task automatic test_blink();
        int c0, c1, c2;
        step_write(2, M_BLINK, 255);
        for (int p = 0; p < 9; p++) begin
            if (p > 0) step_idle();
            measure(0, 0, 0, 0, 0, c0, c1, c2);
            check_cnt($sformatf("blink_p%0d", p), c2, ((p % 8) < 4) ? 255 : 0);
        end
        step_write(2, M_OFF, 255);
        measure(0, 0, 0, 0, 0, c0, c1, c2);
        check_cnt("off_ch2", c2, 0);
    endtask

    task automatic test_breathe();
        int c0, c1, c2;
        int exp_seq[15] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 0};
        step_write(0, M_BREATHE, 3);
        for (int p = 0; p < 15; p++) begin
            if (p > 0) step_idle();
            if (p == 9) measure(1, 0, M_BREATHE, 1, 0, c0, c1, c2);
            else        measure(0, 0, 0, 0, 0, c0, c1, c2);
            check_cnt($sformatf("breathe_p%0d", p), c0, exp_duty(exp_seq[p]));
        end
    endtask

`ifdef LED_PWM_GAMMA_EN
    task automatic test_gamma();
        int c0, c1, c2;
        int lv[3] = '{128, 255, 15};
        int ex[3] = '{64, 255, 0};
        for (int t = 0; t < 3; t++) begin
            step_write(1, M_SOLID, lv[t]);
            measure(0, 0, 0, 0, 0, c0, c1, c2);
            check_cnt($sformatf("gamma_%0d", lv[t]), c1, ex[t]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int c0, c1, c2;
        int first_tick = -1;
        bit any_high = 0;
        step_write(0, M_SOLID, 255);
        measure(0, 0, 0, 0, 0, c0, c1, c2);
        check_cnt("full_scale_ch0", c0, 255);
        step_idle();
        repeat (49) @(negedge clk);
        n_checks++;
        if (pwm_out[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: %b required 1", pwm_out[0]); end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (pwm_out !== 3'b000) begin n_fail++; $display("FAIL mid_reset_pwm: %b required 000", pwm_out); end
        if (period_tick !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tick: %b required 0", period_tick); end
        if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: %b required 0", cfg_if.cfg_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (pwm_out !== 3'b000) any_high = 1;
            if (period_tick && first_tick < 0) first_tick = k;
        end
        check_cnt("post_reset_first_tick", first_tick, 255);
        n_checks++;
        if (any_high) begin n_fail++; $display("FAIL post_reset_pwm: saw high output, required all low"); end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_boundary_sync();
        test_ignored_chan();
        test_blink();
        test_breathe();
`ifdef LED_PWM_GAMMA_EN
        test_gamma();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
